// File: rtl/ft_cmd_parser.sv
// Command framer between the FT232R handshake adapter and a 16-bit register bus.
// Define FT_CMD_CHKSUM_EN to require a trailing XOR checksum byte on every frame.
module ft_cmd_parser #(
    parameter int unsigned P_TIMEOUT_CYCLES = 12_000_000,
    parameter int unsigned P_HS_GUARD       = 4,
    parameter logic [7:0]  P_WR_ACK_BYTE    = 8'h06
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_req,
    output logic        cmd_ack,
    input  logic [7:0]  cmd_data,
    output logic        rsp_req,
    input  logic        rsp_ack,
    output logic [7:0]  rsp_data,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wr_data,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rd_data,
    output logic        err_opcode,
    output logic        err_timeout
);

    localparam int unsigned TW = $clog2(P_TIMEOUT_CYCLES + 1);
    localparam int unsigned GW = (P_HS_GUARD < 2) ? 1 : $clog2(P_HS_GUARD + 1);
    localparam logic [7:0]  OP_WR = 8'h01;
    localparam logic [7:0]  OP_RD = 8'h02;

    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_GUARD} rx_state_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_AH,
        ST_GET_AL,
        ST_GET_DH,
        ST_GET_DL,
`ifdef FT_CMD_CHKSUM_EN
        ST_GET_CK,
`endif
        ST_EXEC_WR,
        ST_EXEC_RD,
        ST_RD_CAP,
        ST_SEND
    } ps_state_t;

    rx_state_t       rx_state;
    ps_state_t       ps;
    logic [7:0]      rx_byte;
    logic            byte_valid;
    logic [GW-1:0]   guard_cnt;
    logic [TW-1:0]   to_cnt;
    logic            discard;
    logic            is_wr;
    logic [15:0]     addr_sh;
    logic [15:0]     data_sh;
    logic [7:0]      rsp_lo;
    logic [1:0]      rsp_cnt;
    logic            in_get;
    logic            parser_open;
    logic            timed_out;
    logic            rx_pending;

    always_comb begin
        in_get = 1'b0;
        case (ps)
            ST_GET_AH, ST_GET_AL, ST_GET_DH, ST_GET_DL: in_get = 1'b1;
`ifdef FT_CMD_CHKSUM_EN
            ST_GET_CK: in_get = 1'b1;
`endif
            default: in_get = 1'b0;
        endcase
        parser_open = in_get || (ps == ST_IDLE);
        timed_out   = in_get && !byte_valid && (to_cnt == TW'(P_TIMEOUT_CYCLES));
        // A byte caught mid-handshake by a timeout must not be parsed as an opcode.
        rx_pending  = (rx_state == RX_ACK) || ((rx_state == RX_IDLE) && cmd_req);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            cmd_ack    <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            guard_cnt  <= '0;
        end else begin
            byte_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (cmd_req && parser_open) begin
                        rx_byte  <= cmd_data;
                        cmd_ack  <= 1'b1;
                        rx_state <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (!cmd_req) begin
                        cmd_ack    <= 1'b0;
                        byte_valid <= 1'b1;
                        guard_cnt  <= GW'(P_HS_GUARD);
                        rx_state   <= RX_GUARD;
                    end
                end
                RX_GUARD: begin
                    if (guard_cnt <= GW'(1)) rx_state <= RX_IDLE;
                    else guard_cnt <= guard_cnt - GW'(1);
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef FT_CMD_CHKSUM_EN
    logic [7:0] chk;

    always_ff @(posedge clk) begin
        if (!rst_n) chk <= '0;
        else if (byte_valid) chk <= (ps == ST_IDLE) ? rx_byte : (chk ^ rx_byte);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps          <= ST_IDLE;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            rsp_req     <= 1'b0;
            rsp_data    <= '0;
            rsp_lo      <= '0;
            rsp_cnt     <= '0;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
            to_cnt      <= '0;
            discard     <= 1'b0;
            is_wr       <= 1'b0;
            addr_sh     <= '0;
            data_sh     <= '0;
        end else begin
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;

            if (in_get && !byte_valid && !timed_out) to_cnt <= to_cnt + TW'(1);
            else to_cnt <= '0;

            case (ps)
                ST_IDLE: begin
                    if (byte_valid) begin
                        if (discard) begin
                            discard <= 1'b0;
                        end else if (rx_byte == OP_WR || rx_byte == OP_RD) begin
                            is_wr <= (rx_byte == OP_WR);
                            ps    <= ST_GET_AH;
                        end else begin
                            err_opcode <= 1'b1;
                        end
                    end
                end
                ST_GET_AH: begin
                    if (byte_valid) begin
                        addr_sh[15:8] <= rx_byte;
                        ps            <= ST_GET_AL;
                    end
                end
                ST_GET_AL: begin
                    if (byte_valid) begin
                        addr_sh[7:0] <= rx_byte;
                        if (is_wr) begin
                            ps <= ST_GET_DH;
                        end else begin
`ifdef FT_CMD_CHKSUM_EN
                            ps <= ST_GET_CK;
`else
                            reg_addr  <= {addr_sh[15:8], rx_byte};
                            reg_rd_en <= 1'b1;
                            ps        <= ST_EXEC_RD;
`endif
                        end
                    end
                end
                ST_GET_DH: begin
                    if (byte_valid) begin
                        data_sh[15:8] <= rx_byte;
                        ps            <= ST_GET_DL;
                    end
                end
                ST_GET_DL: begin
                    if (byte_valid) begin
                        data_sh[7:0] <= rx_byte;
`ifdef FT_CMD_CHKSUM_EN
                        ps <= ST_GET_CK;
`else
                        reg_addr    <= addr_sh;
                        reg_wr_data <= {data_sh[15:8], rx_byte};
                        reg_wr_en   <= 1'b1;
                        ps          <= ST_EXEC_WR;
`endif
                    end
                end
`ifdef FT_CMD_CHKSUM_EN
                ST_GET_CK: begin
                    if (byte_valid) begin
                        if ((chk ^ rx_byte) != 8'h00) begin
                            rsp_data <= 8'hEE;
                            rsp_cnt  <= 2'd1;
                            rsp_req  <= 1'b1;
                            ps       <= ST_SEND;
                        end else if (is_wr) begin
                            reg_addr    <= addr_sh;
                            reg_wr_data <= data_sh;
                            reg_wr_en   <= 1'b1;
                            ps          <= ST_EXEC_WR;
                        end else begin
                            reg_addr  <= addr_sh;
                            reg_rd_en <= 1'b1;
                            ps        <= ST_EXEC_RD;
                        end
                    end
                end
`endif
                ST_EXEC_WR: begin
                    rsp_data <= P_WR_ACK_BYTE;
                    rsp_cnt  <= 2'd1;
                    rsp_req  <= 1'b1;
                    ps       <= ST_SEND;
                end
                ST_EXEC_RD: ps <= ST_RD_CAP;
                ST_RD_CAP: begin
                    rsp_data <= reg_rd_data[15:8];
                    rsp_lo   <= reg_rd_data[7:0];
                    rsp_cnt  <= 2'd2;
                    rsp_req  <= 1'b1;
                    ps       <= ST_SEND;
                end
                ST_SEND: begin
                    // rsp_req low for one cycle between bytes gives the adapter a fresh rising edge.
                    if (rsp_req) begin
                        if (rsp_ack) begin
                            rsp_req <= 1'b0;
                            rsp_cnt <= rsp_cnt - 2'd1;
                            if (rsp_cnt == 2'd1) ps <= ST_IDLE;
                            else rsp_data <= rsp_lo;
                        end
                    end else begin
                        rsp_req <= 1'b1;
                    end
                end
                default: ps <= ST_IDLE;
            endcase

            if (timed_out) begin
                err_timeout <= 1'b1;
                discard     <= rx_pending;
                ps          <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ft_cmd_parser.sv
// Scoreboard bench for ft_cmd_parser: stimulus pushes expectations, a monitor pops them.
module tb_ft_cmd_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_req;
    logic        cmd_ack;
    logic [7:0]  cmd_data;
    logic        rsp_req;
    logic        rsp_ack;
    logic [7:0]  rsp_data;
    logic [15:0] reg_addr;
    logic [15:0] reg_wr_data;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data;
    logic        err_opcode;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [7:0]  exp_rsp[$];
    int          exp_err[$];
    logic [15:0] rd_value = 16'h0000;

    ft_cmd_parser #(
        .P_TIMEOUT_CYCLES(100),
        .P_HS_GUARD(4),
        .P_WR_ACK_BYTE(8'h06)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_req(cmd_req),
        .cmd_ack(cmd_ack),
        .cmd_data(cmd_data),
        .rsp_req(rsp_req),
        .rsp_ack(rsp_ack),
        .rsp_data(rsp_data),
        .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data),
        .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en),
        .reg_rd_data(reg_rd_data),
        .err_opcode(err_opcode),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Register bus model: read data only valid the cycle after the strobe.
    always @(posedge clk) reg_rd_data <= reg_rd_en ? rd_value : 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Adapter model: acknowledge each raised request two cycles later.
    initial begin
        rsp_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_req) begin
                repeat (2) @(negedge clk);
                rsp_ack = 1'b1;
                @(negedge clk);
                rsp_ack = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        logic        req_prev;
        logic [31:0] w;
        req_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reg_wr_en) begin
                if (exp_wr.size() == 0) check("unexpected_wr_strobe", 32'd1, 32'd0);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", {16'h0, reg_addr}, {16'h0, w[31:16]});
                    check("wr_data", {16'h0, reg_wr_data}, {16'h0, w[15:0]});
                end
            end
            if (reg_rd_en) begin
                if (exp_rd.size() == 0) check("unexpected_rd_strobe", 32'd1, 32'd0);
                else check("rd_addr", {16'h0, reg_addr}, {16'h0, exp_rd.pop_front()});
            end
            if (rsp_req && !req_prev) begin
                if (exp_rsp.size() == 0) check("unexpected_rsp", {24'h0, rsp_data}, 32'hFFFF_FFFF);
                else check("rsp_byte", {24'h0, rsp_data}, {24'h0, exp_rsp.pop_front()});
            end
            if (rsp_ack && req_prev) check("rsp_req_drop", {31'h0, rsp_req}, 32'd0);
            if (err_opcode) begin
                if (exp_err.size() == 0) check("unexpected_err_opcode", 32'd1, 32'd0);
                else check("err_kind_opcode", 32'd1, exp_err.pop_front());
            end
            if (err_timeout) begin
                if (exp_err.size() == 0) check("unexpected_err_timeout", 32'd1, 32'd0);
                else check("err_kind_timeout", 32'd2, exp_err.pop_front());
            end
            req_prev = rsp_req;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        cmd_data = b;
        cmd_req  = 1'b1;
        n = 0;
        while (!cmd_ack && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ack) check("cmd_ack_rise_wait", 32'd0, 32'd1);
        cmd_req = 1'b0;
        n = 0;
        while (cmd_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ack) check("cmd_ack_fall_wait", 32'd1, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] addr,
                              input logic [15:0] data);
        logic [7:0] ck;
        ck = op ^ addr[15:8] ^ addr[7:0];
        send_byte(op);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        if (op == 8'h01) begin
            send_byte(data[15:8]);
            send_byte(data[7:0]);
            ck = ck ^ data[15:8] ^ data[7:0];
        end
`ifdef FT_CMD_CHKSUM_EN
        send_byte(ck);
`else
        ck = 8'h00;
`endif
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_rsp.size() + exp_err.size() != 0 || rsp_req)
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_wr.size() + exp_rd.size() + exp_rsp.size() + exp_err.size()
                    + {31'h0, rsp_req}, 32'd0);
        exp_wr.delete();
        exp_rd.delete();
        exp_rsp.delete();
        exp_err.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ack"}, {31'h0, cmd_ack}, 32'd0);
        check({tag, "_rsp_req"}, {31'h0, rsp_req}, 32'd0);
        check({tag, "_rsp_data"}, {24'h0, rsp_data}, 32'd0);
        check({tag, "_reg_addr"}, {16'h0, reg_addr}, 32'd0);
        check({tag, "_reg_wr_data"}, {16'h0, reg_wr_data}, 32'd0);
        check({tag, "_strobes"}, {30'h0, reg_wr_en, reg_rd_en}, 32'd0);
        check({tag, "_errs"}, {30'h0, err_opcode, err_timeout}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        cmd_req  = 1'b0;
        cmd_data = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Write frame
        exp_wr.push_back({16'h1234, 16'hBEEF});
        exp_rsp.push_back(8'h06);
        send_frame(8'h01, 16'h1234, 16'hBEEF);
        wait_drain("drain_write");

        // Read frame, two response bytes
        rd_value = 16'hCAFE;
        exp_rd.push_back(16'h0010);
        exp_rsp.push_back(8'hCA);
        exp_rsp.push_back(8'hFE);
        send_frame(8'h02, 16'h0010, 16'h0000);
        wait_drain("drain_read");

        // Unknown opcode, then a normal read
        exp_err.push_back(1);
        send_byte(8'h7F);
        rd_value = 16'h0BAD;
        exp_rd.push_back(16'h0001);
        exp_rsp.push_back(8'h0B);
        exp_rsp.push_back(8'hAD);
        send_frame(8'h02, 16'h0001, 16'h0000);
        wait_drain("drain_badop");

        // Partial frame timeout
        exp_err.push_back(2);
        send_byte(8'h01);
        send_byte(8'h12);
        n = 0;
        while (!err_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency_in_range", {31'h0, (n >= 100 && n <= 103)}, 32'd1);
        check("hold_addr_after_timeout", {16'h0, reg_addr}, 32'h0001);
        check("hold_wdata_after_timeout", {16'h0, reg_wr_data}, 32'hBEEF);
        rd_value = 16'h4242;
        exp_rd.push_back(16'h0001);
        exp_rsp.push_back(8'h42);
        exp_rsp.push_back(8'h42);
        send_frame(8'h02, 16'h0001, 16'h0000);
        wait_drain("drain_timeout");

        // Re-pulse of cmd_req inside the guard window must be ignored
        exp_wr.push_back({16'hABCD, 16'h1357});
        exp_rsp.push_back(8'h06);
        send_byte(8'h01);
        @(negedge clk);
        cmd_data = 8'h55;
        cmd_req  = 1'b1;
        @(negedge clk);
        check("guard_noack_1", {31'h0, cmd_ack}, 32'd0);
        @(negedge clk);
        check("guard_noack_2", {31'h0, cmd_ack}, 32'd0);
        cmd_req = 1'b0;
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h13);
        send_byte(8'h57);
`ifdef FT_CMD_CHKSUM_EN
        send_byte(8'h01 ^ 8'hAB ^ 8'hCD ^ 8'h13 ^ 8'h57);
`endif
        wait_drain("drain_guard");

        // Reset during response
        rd_value = 16'h1357;
        exp_rd.push_back(16'h0020);
        exp_rsp.push_back(8'h13);
        send_frame(8'h02, 16'h0020, 16'h0000);
        n = 0;
        while (!rsp_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rsp_req_before_reset", {31'h0, rsp_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_wr.push_back({16'h0FF0, 16'hA55A});
        exp_rsp.push_back(8'h06);
        send_frame(8'h01, 16'h0FF0, 16'hA55A);
        wait_drain("drain_after_reset");

`ifdef FT_CMD_CHKSUM_EN
        // Bad checksum: no strobe, error response
        exp_rsp.push_back(8'hEE);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h02);
        wait_drain("drain_badck");
        check("badck_addr_held", {16'h0, reg_addr}, 32'h0FF0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
